// File: rtl/lamp_sequence_monitor_pkg.sv
// Shared lamp-bus definitions: lamp codes, decoded phases, error codes and monitor states.
// Used by the lamp sequence monitor and its code decoder.
package lamp_sequence_monitor_pkg;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_GREEN  = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b001;

    typedef enum logic [1:0] {
        PH_RED    = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2,
        PH_NONE   = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_ORDER   = 2'd2,
        ERR_STUCK   = 2'd3
    } err_t;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_TRACK,
        ST_FAULT
    } state_t;

    // Legal successor in the RED -> GREEN -> YELLOW -> RED ring.
    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_RED:    next_phase = PH_GREEN;
            PH_GREEN:  next_phase = PH_YELLOW;
            PH_YELLOW: next_phase = PH_RED;
            default:   next_phase = PH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/lamp_code_decoder.sv
// Combinational decode of the one-hot lamp bus into a phase plus a validity flag.
// Anything other than a single lit lamp is reported invalid with phase PH_NONE.
module lamp_code_decoder
    import lamp_sequence_monitor_pkg::*;
(
    input  logic [0:2] light,
    output logic       valid,
    output phase_t     phase
);

    always_comb begin
        valid = 1'b1;
        phase = PH_NONE;
        case (light)
            LAMP_RED:    phase = PH_RED;
            LAMP_GREEN:  phase = PH_GREEN;
            LAMP_YELLOW: phase = PH_YELLOW;
            default:     valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/lamp_sequence_monitor.sv
// Receive-side checker for the traffic-lamp bus: tracks phase order and dwell time,
// counts completed cycles and latches a sticky fault until clear or reset.
module lamp_sequence_monitor
    import lamp_sequence_monitor_pkg::*;
#(
    parameter int MAX_DWELL = 4,
    parameter int DW_W      = 3,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [0:2]       light,
    input  logic             clear,
    output logic [1:0]       phase,
    output logic             locked,
    output logic             seq_error,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [DW_W-1:0]  dwell
);

    localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(MAX_DWELL);
    localparam logic [DW_W-1:0] DWELL_SAT = DW_W'(MAX_DWELL + 1);

    state_t           state, state_next;
    phase_t           phase_r, phase_next;
    err_t             err_r, err_next;
    logic [DW_W-1:0]  dwell_r, dwell_next, dwell_inc;
    logic [CNT_W-1:0] count_r, count_next;

    logic   dec_valid;
    phase_t dec_phase;

    lamp_code_decoder u_decoder (
        .light (light),
        .valid (dec_valid),
        .phase (dec_phase)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_SYNC;
            phase_r <= PH_NONE;
            err_r   <= ERR_NONE;
            dwell_r <= '0;
            count_r <= '0;
        end else begin
            state   <= state_next;
            phase_r <= phase_next;
            err_r   <= err_next;
            dwell_r <= dwell_next;
            count_r <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        phase_next = phase_r;
        err_next   = err_r;
        dwell_next = dwell_r;
        count_next = count_r;
        dwell_inc  = (dwell_r == DWELL_SAT) ? dwell_r : dwell_r + DW_W'(1);

        // clear outranks any detection on the same edge; the sample is dropped.
        if (clear) begin
            state_next = ST_SYNC;
            phase_next = PH_NONE;
            err_next   = ERR_NONE;
            dwell_next = '0;
            count_next = '0;
        end else begin
            case (state)
                ST_SYNC: begin
                    if (dec_valid) begin
                        state_next = ST_TRACK;
                        phase_next = dec_phase;
                        dwell_next = DW_W'(1);
                    end else begin
                        phase_next = PH_NONE;
                    end
                end
                ST_TRACK: begin
                    if (!dec_valid) begin
                        state_next = ST_FAULT;
                        err_next   = ERR_ILLEGAL;
                    end else if (dec_phase == phase_r) begin
                        dwell_next = dwell_inc;
                        if (dwell_inc > DWELL_MAX) begin
                            state_next = ST_FAULT;
                            err_next   = ERR_STUCK;
                        end
                    end else if (dec_phase == next_phase(phase_r)) begin
                        phase_next = dec_phase;
                        dwell_next = DW_W'(1);
                        if (phase_r == PH_YELLOW) begin
                            count_next = count_r + CNT_W'(1);
                        end
                    end else begin
                        state_next = ST_FAULT;
                        err_next   = ERR_ORDER;
                    end
                end
                ST_FAULT: begin
                    state_next = ST_FAULT;
                end
                default: begin
                    state_next = ST_SYNC;
                    phase_next = PH_NONE;
                end
            endcase
        end
    end

    always_comb begin
        locked      = (state == ST_TRACK);
        seq_error   = (state == ST_FAULT);
        phase       = phase_r;
        err_code    = err_r;
        dwell       = dwell_r;
        cycle_count = count_r;
    end

endmodule
